// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor: mode constants,
// counter init value and the index/tag extraction used by predictor and checker.
package branch_predictor_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic logic [31:0] ctr_init(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] low_mask(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] btb_index(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & low_mask(idx_w);
  endfunction

  function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int unsigned idx_w,
                                          input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & low_mask(tag_w);
  endfunction

  function automatic logic [31:0] pht_index(input logic [31:0] bidx, input logic [31:0] hist,
                                            input int mode);
    return (mode == MODE_GSHARE) ? (bidx ^ hist) : bidx;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, EX-side update and statistics signals of the branch predictor.
interface branch_predictor_if #(
  parameter int HIST_W = 6,
  parameter int CNT_W  = 32
);
  logic [31:0]       pc_i;
  logic              pred_hit_o;
  logic              pred_taken_o;
  logic [31:0]       pred_next_pc_o;
  logic [HIST_W-1:0] pred_hist_o;
  logic              upd_valid_i;
  logic [31:0]       upd_pc_i;
  logic              upd_taken_i;
  logic [31:0]       upd_target_i;
  logic [HIST_W-1:0] upd_hist_i;
  logic              upd_mispred_i;
  logic [CNT_W-1:0]  stat_branches_o;
  logic [CNT_W-1:0]  stat_mispred_o;

  modport master (
    output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_hist_i, upd_mispred_i,
    input  pred_hit_o, pred_taken_o, pred_next_pc_o, pred_hist_o, stat_branches_o, stat_mispred_o
  );

  modport slave (
    input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_hist_i, upd_mispred_i,
    output pred_hit_o, pred_taken_o, pred_next_pc_o, pred_hist_o, stat_branches_o, stat_mispred_o
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// CTR_W-wide saturating up/down counter; resets asynchronously to weakly-not-taken.
module sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [CTR_W-1:0] count
);

  localparam logic [CTR_W-1:0] INIT = CTR_W'(ctr_init(CTR_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= INIT;
    end else if (en) begin
      if (up && (count != '1)) begin
        count <= count + CTR_W'(1);
      end else if (!up && (count != '0)) begin
        count <= count - CTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit-counter PHT, bimodal or gshare indexed.
// Combinational lookup from registered state; update on the clock edge from EX.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int MODE    = 0,
  parameter int HIST_W  = 6,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  branch_predictor_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic              btb_valid  [ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q  [ENTRIES];
  logic [31:0]       btb_target [ENTRIES];
  logic [CTR_W-1:0]  pht        [ENTRIES];
  logic [HIST_W-1:0] ghr;
  logic [CNT_W-1:0]  stat_branches;
  logic [CNT_W-1:0]  stat_mispred;

  logic [31:0] look_bidx_w, look_tag_w, look_pidx_w;
  logic [31:0] upd_bidx_w, upd_tag_w, upd_pidx_w;
  logic [IDX_W-1:0] look_bidx, look_pidx, upd_bidx, upd_pidx;
  logic [TAG_W-1:0] look_tag, upd_tag;
  logic hit, taken;
  logic unused_bits;

  assign look_bidx_w = btb_index(bus.pc_i, IDX_W);
  assign look_tag_w  = btb_tag(bus.pc_i, IDX_W, TAG_W);
  assign look_pidx_w = pht_index(look_bidx_w, 32'(ghr), MODE);
  assign upd_bidx_w  = btb_index(bus.upd_pc_i, IDX_W);
  assign upd_tag_w   = btb_tag(bus.upd_pc_i, IDX_W, TAG_W);
  assign upd_pidx_w  = pht_index(upd_bidx_w, 32'(bus.upd_hist_i), MODE);

  assign look_bidx = look_bidx_w[IDX_W-1:0];
  assign look_pidx = look_pidx_w[IDX_W-1:0];
  assign look_tag  = look_tag_w[TAG_W-1:0];
  assign upd_bidx  = upd_bidx_w[IDX_W-1:0];
  assign upd_pidx  = upd_pidx_w[IDX_W-1:0];
  assign upd_tag   = upd_tag_w[TAG_W-1:0];

  assign unused_bits = ^{look_bidx_w, look_tag_w, look_pidx_w, upd_bidx_w, upd_tag_w, upd_pidx_w};

  // Lookup: zero-cycle read of state registered at the last edge, no bypass.
  assign hit   = btb_valid[look_bidx] && (btb_tag_q[look_bidx] == look_tag);
  assign taken = hit && pht[look_pidx][CTR_W-1];

  assign bus.pred_hit_o      = hit;
  assign bus.pred_taken_o    = taken;
  assign bus.pred_next_pc_o  = taken ? btb_target[look_bidx] : bus.pc_i + 32'd4;
  assign bus.pred_hist_o     = (MODE == MODE_GSHARE) ? ghr : '0;
  assign bus.stat_branches_o = stat_branches;
  assign bus.stat_mispred_o  = stat_mispred;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_pht
    sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk   (clk_i),
      .rst   (rst_i),
      .en    (bus.upd_valid_i && (upd_pidx == IDX_W'(e))),
      .up    (bus.upd_taken_i),
      .count (pht[e])
    );
  end

  // Update: only taken branches allocate or overwrite a BTB entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag_q[i]  <= '0;
        btb_target[i] <= '0;
      end
    end else if (bus.upd_valid_i && bus.upd_taken_i) begin
      btb_valid[upd_bidx]  <= 1'b1;
      btb_tag_q[upd_bidx]  <= upd_tag;
      btb_target[upd_bidx] <= bus.upd_target_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr           <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (bus.upd_valid_i) begin
      if (MODE == MODE_GSHARE) begin
        ghr <= HIST_W'({ghr, bus.upd_taken_i});
      end
      if (stat_branches != '1) begin
        stat_branches <= stat_branches + CNT_W'(1);
      end
      if (bus.upd_mispred_i && (stat_mispred != '1)) begin
        stat_mispred <= stat_mispred + CNT_W'(1);
      end
    end
  end

endmodule
